mult_batch_sequencer: RTL and testbench
=======================================

// Module: mult_batch_sequencer
// PURPOSE
//  Sequences one multiplier batch: arm via EN_mult, stream operand pairs while RDY_mult, request block readback.
//  Forwards each read-back product on a result stream tagged with its index.
//  Sits between the host-side operand/result streams and the multiplier core. Detects operand underrun and handshake timeouts.
// PARAMETERS
//  LOGDEPTH  6     log2 of batch depth; index width
//  WIDTH     32    product / result width
//  OPW       16    operand width
//  TIMEOUT   1024  max cycles waiting on RDY_mult / VALID_memVal edge before error
// PORTS
//  clk           in   1         clock
//  rst           in   1         synchronous active-high reset
//  start         in   1         begin a batch; honoured only in IDLE
//  op_valid      in   1         operand pair available
//  op_a          in   OPW       operand 0
//  op_b          in   OPW       operand 1
//  op_ready      out  1         operand pair consumed this cycle
//  EN_mult       out  1         to multiplier: start multiplication
//  RDY_mult      in   1         from multiplier: accepting operands this cycle
//  mult_input0   out  OPW       to multiplier operand 0
//  mult_input1   out  OPW       to multiplier operand 1
//  EN_blockRead  out  1         to multiplier: read block back
//  VALID_memVal  in   1         from multiplier: memVal_data valid
//  memVal_data   in   WIDTH     from multiplier: read-back product
//  res_valid     out  1         result word valid (no backpressure)
//  res_data      out  WIDTH     result word
//  res_idx       out  LOGDEPTH  result index, 0-based
//  busy          out  1         not in IDLE
//  done          out  1         one-cycle pulse, batch finished cleanly
//  err_underrun  out  1         sticky: op_valid low while RDY_mult high in FEED
//  err_timeout   out  1         sticky: timeout hit
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; counters and sticky flags cleared.
//  Clock and reset names are clk/rst; reset is synchronous, active-high. Shared rst also resets the multiplier.
//  FSM (state_t in package): IDLE, ARM, FEED, WAIT_RD, READ, DONE, ERR.
//   IDLE: start=1 -> clear sticky flags, counters -> ARM. start in any other state ignored.
//   ARM: EN_mult=1 for exactly one cycle -> FEED.
//   FEED: each cycle RDY_mult=1: if op_valid, op_ready=1 and mult_input0/1=op_a/op_b (combinational);
//    else mult_input0/1=0, op_ready=0, err_underrun<=1 (slot filled with 0, batch continues).
//    feed_cnt increments per RDY_mult cycle. RDY_mult 1->0 after feed_cnt>=1 -> WAIT_RD.
//    RDY_mult never high within TIMEOUT cycles of entry -> ERR.
//   WAIT_RD: EN_blockRead=1 held until first VALID_memVal=1 -> READ (that beat is forwarded).
//    TIMEOUT cycles with no VALID_memVal -> ERR.
//   READ: VALID_memVal=1 -> res_valid=1, res_data=memVal_data, res_idx=rd_cnt, rd_cnt++ (registered: one-cycle latency).
//    VALID_memVal 1->0 -> DONE. rd_cnt wraps mod 2^LOGDEPTH, no stall.
//   DONE: done=1 one cycle -> IDLE.
//   ERR: err_timeout<=1, EN_mult/EN_blockRead=0 -> IDLE next cycle; done not pulsed.
//  mult_input0/1 are 0 outside FEED. op_ready is never 1 outside FEED.
//  Timeout counter: clears on every state change and saturates at TIMEOUT.
//  Sticky flags clear only on accepted start or rst.
//  Reset mid-batch: immediate return to IDLE, outputs to reset values; partial results discarded.
// STRUCTURE
//  Package mult_seq_pkg: state_t enum, TIMEOUT_DEFAULT, DEPTH = 1<<LOGDEPTH.
//  One sub-module: seq_timeout_ctr (load/clear, saturating count, expired flag). The remainder is flat in the FSM.
// TESTING
//  1. Happy path: start, op stream always valid with a=i, b=i+1 -> EN_mult one pulse, res_data[i]=i*(i+1), done pulse.
//  2. Underrun: op_valid low for 3 RDY_mult cycles -> err_underrun=1, those slots in mult_input are 0, batch still completes, done=1.
//  3. RDY_mult held 0 after ARM -> err_timeout=1 at TIMEOUT+1 cycles, busy=0, no done.
//  4. VALID_memVal never asserts in WAIT_RD -> EN_blockRead held high, then err_timeout=1 and return to IDLE.
//  5. start pulsed during FEED/READ -> ignored; next start in IDLE clears sticky flags.
//  6. rst asserted mid-READ -> next cycle all outputs 0, state IDLE; new batch then runs clean.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the multiplier batch sequencer.
//   state_t          : sequencer FSM states
//   TIMEOUT_DEFAULT  : default handshake timeout in cycles
//   LOGDEPTH_DEFAULT : default log2 of batch depth
//   DEPTH            : batch depth for the default index width
package mult_seq_pkg;

   localparam int TIMEOUT_DEFAULT  = 1024;
   localparam int LOGDEPTH_DEFAULT = 6;
   localparam int DEPTH            = 1 << LOGDEPTH_DEFAULT;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_FEED,
      S_WAIT_RD,
      S_READ,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Saturating cycle counter used as the handshake watchdog.
//   clk       : clock
//   rst       : synchronous active-high reset
//   clr_i     : restart the count from zero this cycle
//   expired_o : count has reached MAX (stays high until cleared)
module seq_timeout_ctr
   import mult_seq_pkg::*;
#(
   parameter int MAX = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic expired_o
);

   localparam int             CW    = $clog2(MAX + 1);
   localparam logic [CW-1:0]  MAX_C = CW'(MAX);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != MAX_C) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mult_batch_sequencer.sv
// Sequences one batch through an external multiplier core: arms it, streams
// operand pairs while it is ready, requests block readback and forwards each
// product on an indexed result stream. Flags operand underrun and timeouts.
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : begin a batch (IDLE only)
//   op_valid/op_a/op_b/op_ready : host operand stream
//   EN_mult/RDY_mult            : multiplier start / operand acceptance
//   mult_input0/mult_input1     : operands to the multiplier
//   EN_blockRead                : request multiplier readback
//   VALID_memVal/memVal_data    : read-back product beats
//   res_valid/res_data/res_idx  : result stream (registered, no backpressure)
//   busy/done                   : not idle / clean-finish pulse
//   err_underrun/err_timeout    : sticky error flags
module mult_batch_sequencer
   import mult_seq_pkg::*;
#(
   parameter int LOGDEPTH = LOGDEPTH_DEFAULT,
   parameter int WIDTH    = 32,
   parameter int OPW      = 16,
   parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                op_valid,
   input  logic [OPW-1:0]      op_a,
   input  logic [OPW-1:0]      op_b,
   output logic                op_ready,
   output logic                EN_mult,
   input  logic                RDY_mult,
   output logic [OPW-1:0]      mult_input0,
   output logic [OPW-1:0]      mult_input1,
   output logic                EN_blockRead,
   input  logic                VALID_memVal,
   input  logic [WIDTH-1:0]    memVal_data,
   output logic                res_valid,
   output logic [WIDTH-1:0]    res_data,
   output logic [LOGDEPTH-1:0] res_idx,
   output logic                busy,
   output logic                done,
   output logic                err_underrun,
   output logic                err_timeout
);

   // Feed count only needs to tell "nothing fed yet" from "something fed",
   // so it saturates one bit above the index range instead of wrapping.
   localparam logic [LOGDEPTH:0] FEED_MAX = {1'b1, {LOGDEPTH{1'b0}}};

   state_t                state_q, state_d;
   logic [LOGDEPTH:0]     feed_cnt_q, feed_cnt_d;
   logic [LOGDEPTH-1:0]   rd_cnt_q, rd_cnt_d;
   logic                  err_underrun_q, err_underrun_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  res_valid_q, res_valid_d;
   logic [WIDTH-1:0]      res_data_q, res_data_d;
   logic [LOGDEPTH-1:0]   res_idx_q, res_idx_d;
   logic                  tmr_expired;

   // Watchdog restarts on every state change, so it measures time spent in
   // the current state only.
   seq_timeout_ctr #(
      .MAX(TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (state_d != state_q),
      .expired_o(tmr_expired)
   );

   always_comb begin
      state_d        = state_q;
      feed_cnt_d     = feed_cnt_q;
      rd_cnt_d       = rd_cnt_q;
      err_underrun_d = err_underrun_q;
      err_timeout_d  = err_timeout_q;
      res_valid_d    = 1'b0;
      res_data_d     = res_data_q;
      res_idx_d      = res_idx_q;
      EN_mult        = 1'b0;
      EN_blockRead   = 1'b0;
      op_ready       = 1'b0;
      mult_input0    = '0;
      mult_input1    = '0;
      done           = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_underrun_d = 1'b0;
               err_timeout_d  = 1'b0;
               feed_cnt_d     = '0;
               rd_cnt_d       = '0;
               state_d        = S_ARM;
            end
         end
         S_ARM: begin
            EN_mult = 1'b1;
            state_d = S_FEED;
         end
         S_FEED: begin
            if (RDY_mult) begin
               if (feed_cnt_q != FEED_MAX) begin
                  feed_cnt_d = feed_cnt_q + 1'b1;
               end
               if (op_valid) begin
                  op_ready    = 1'b1;
                  mult_input0 = op_a;
                  mult_input1 = op_b;
               end else begin
                  // Starved slot: multiplier still consumes a zero pair.
                  err_underrun_d = 1'b1;
               end
            end else if (feed_cnt_q != '0) begin
               // Ready has dropped after at least one accepted slot.
               state_d = S_WAIT_RD;
            end else if (tmr_expired) begin
               state_d = S_ERR;
            end
         end
         S_WAIT_RD: begin
            EN_blockRead = 1'b1;
            if (VALID_memVal) begin
               res_valid_d = 1'b1;
               res_data_d  = memVal_data;
               res_idx_d   = rd_cnt_q;
               rd_cnt_d    = rd_cnt_q + 1'b1;
               state_d     = S_READ;
            end else if (tmr_expired) begin
               state_d = S_ERR;
            end
         end
         S_READ: begin
            if (VALID_memVal) begin
               res_valid_d = 1'b1;
               res_data_d  = memVal_data;
               res_idx_d   = rd_cnt_q;
               rd_cnt_d    = rd_cnt_q + 1'b1;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         feed_cnt_q     <= '0;
         rd_cnt_q       <= '0;
         err_underrun_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
         res_idx_q      <= '0;
      end else begin
         state_q        <= state_d;
         feed_cnt_q     <= feed_cnt_d;
         rd_cnt_q       <= rd_cnt_d;
         err_underrun_q <= err_underrun_d;
         err_timeout_q  <= err_timeout_d;
         res_valid_q    <= res_valid_d;
         res_data_q     <= res_data_d;
         res_idx_q      <= res_idx_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign err_underrun = err_underrun_q;
   assign err_timeout  = err_timeout_q;
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign res_idx      = res_idx_q;

endmodule

// File: tb/tb_mult_batch_sequencer.sv
// Directed bench for mult_batch_sequencer with a behavioural multiplier model
// and a result scoreboard.
module tb_mult_batch_sequencer;

   localparam int LOGDEPTH = 6;
   localparam int WIDTH    = 32;
   localparam int OPW      = 16;
   localparam int TO       = 16;

   logic                clk = 1'b0;
   logic                rst, start, op_valid, RDY_mult, VALID_memVal;
   logic [OPW-1:0]      op_a, op_b;
   logic [WIDTH-1:0]    memVal_data;
   logic                op_ready, EN_mult, EN_blockRead, res_valid, busy, done;
   logic                err_underrun, err_timeout;
   logic [OPW-1:0]      mult_input0, mult_input1;
   logic [WIDTH-1:0]    res_data;
   logic [LOGDEPTH-1:0] res_idx;

   always #5 clk = ~clk;

   mult_batch_sequencer #(
      .LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .OPW(OPW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
      .EN_mult(EN_mult), .RDY_mult(RDY_mult),
      .mult_input0(mult_input0), .mult_input1(mult_input1),
      .EN_blockRead(EN_blockRead), .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
      .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
      .busy(busy), .done(done), .err_underrun(err_underrun), .err_timeout(err_timeout)
   );

   typedef struct packed {
      logic [LOGDEPTH-1:0] idx;
      logic [WIDTH-1:0]    data;
   } exp_t;

   exp_t             sb[$];
   exp_t             e_mon;
   logic [WIDTH-1:0] mem [128];   // multiplier model product storage
   int               n_checks = 0;
   int               n_fail   = 0;
   int               done_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Result monitor: every forwarded word must match the oldest expectation.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (res_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("res_unexpected", {63'd0, res_valid}, 64'd0);
         end else begin
            e_mon = sb.pop_front();
            check("res_data", res_data, e_mon.data);
            check("res_idx", res_idx, e_mon.idx);
         end
      end
   end

   task automatic check_idle(input string tag);
      $display("%s: checking idle outputs", tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_en_mult"}, EN_mult, 0);
      check({tag, "_en_blockread"}, EN_blockRead, 0);
      check({tag, "_op_ready"}, op_ready, 0);
      check({tag, "_mult_in0"}, mult_input0, 0);
      check({tag, "_mult_in1"}, mult_input1, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_data"}, res_data, 0);
      check({tag, "_res_idx"}, res_idx, 0);
      check({tag, "_err_underrun"}, err_underrun, 0);
      check({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   task automatic start_batch();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; #1;
      $display("start: EN_mult=%0b busy=%0b", EN_mult, busy);
      check("arm_en_mult", EN_mult, 1);
      check("arm_busy", busy, 1);
      check("start_clears_underrun", err_underrun, 0);
      check("start_clears_timeout", err_timeout, 0);
   endtask

   task automatic feed(input int n, input logic [127:0] under, input bit start_mid);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         RDY_mult = 1'b1;
         op_valid = !under[i];
         op_a     = OPW'(i);
         op_b     = OPW'(i + 1);
         start    = start_mid && (i == 1);
         #1;
         $display("feed %0d: valid=%0b in0=%0d in1=%0d ready=%0b", i, op_valid, mult_input0, mult_input1, op_ready);
         check("feed_op_ready", op_ready, under[i] ? 0 : 1);
         check("feed_mult_in0", mult_input0, under[i] ? 0 : i);
         check("feed_mult_in1", mult_input1, under[i] ? 0 : i + 1);
         check("feed_en_mult_low", EN_mult, 0);
         mem[i] = WIDTH'(mult_input0) * WIDTH'(mult_input1);
         e.idx  = LOGDEPTH'(i);
         e.data = under[i] ? '0 : WIDTH'(i * (i + 1));
         sb.push_back(e);
      end
      @(negedge clk);
      RDY_mult = 1'b0; op_valid = 1'b0; start = 1'b0;
   endtask

   task automatic read_back(input int n, input bit start_mid, input int rst_at);
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      op_valid = 1'b1; op_a = 16'hdead; op_b = 16'hbeef; #1;
      check("wait_en_blockread", EN_blockRead, 1);
      check("wait_op_ready_low", op_ready, 0);
      check("wait_mult_in0_zero", mult_input0, 0);
      @(negedge clk);
      op_valid = 1'b0; #1;
      check("wait_en_blockread_hold", EN_blockRead, 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == rst_at) begin
            rst = 1'b1; VALID_memVal = 1'b0; start = 1'b0;
            @(negedge clk); #1;
            check_idle("rst_mid_read");
            rst = 1'b0;
            sb.delete();
            return;
         end
         VALID_memVal = 1'b1;
         memVal_data  = mem[i];
         start        = start_mid && (i == 2);
         #1;
         check("beat_en_blockread", EN_blockRead, (i == 0) ? 1 : 0);
      end
      @(negedge clk);
      VALID_memVal = 1'b0; start = 1'b0;
      @(negedge clk); #1;
      $display("read done: done=%0b busy=%0b", done, busy);
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      @(negedge clk); #1;
      check("after_done_low", done, 0);
      check("after_done_idle", busy, 0);
      check("sb_drained", sb.size(), 0);
      check("done_count", done_cnt, d0 + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c;
      int d0;
      rst = 1'b1; start = 1'b0; op_valid = 1'b1; op_a = 16'h1234; op_b = 16'h5678;
      RDY_mult = 1'b1; VALID_memVal = 1'b0; memVal_data = '0;
      repeat (3) @(negedge clk);
      #1;
      check_idle("reset");
      rst = 1'b0; op_valid = 1'b0; RDY_mult = 1'b0;

      // 1. happy path
      start_batch();
      feed(8, '0, 1'b0);
      read_back(8, 1'b0, -1);
      check("happy_no_underrun", err_underrun, 0);

      // 2. underrun on slots 2..4
      start_batch();
      feed(8, 128'b11100, 1'b0);
      read_back(8, 1'b0, -1);
      check("underrun_flag", err_underrun, 1);
      check("underrun_no_timeout", err_timeout, 0);

      // 3. multiplier never ready
      d0 = done_cnt;
      start_batch();
      op_valid = 1'b1; op_a = 16'h0005;
      c = 0;
      while (c < 4 * TO) begin
         @(negedge clk); #1;
         c++;
         if (c == 2) begin
            check("no_rdy_op_ready", op_ready, 0);
            check("no_rdy_mult_in0", mult_input0, 0);
         end
         if (err_timeout === 1'b1) break;
      end
      op_valid = 1'b0;
      $display("feed timeout after %0d cycles", c);
      check("feed_timeout_cycles", c, TO + 3);
      check("feed_timeout_busy", busy, 0);
      check("feed_timeout_no_done", done_cnt, d0);

      // 4. readback never valid
      d0 = done_cnt;
      start_batch();
      feed(4, '0, 1'b0);
      for (c = 0; c < 4 * TO; c++) begin
         @(negedge clk); #1;
         if (err_timeout === 1'b1) break;
         if (c <= TO) check("rd_en_blockread_held", EN_blockRead, 1);
         if (c == TO + 1) check("rd_err_en_blockread_low", EN_blockRead, 0);
      end
      sb.delete();
      $display("read timeout after %0d cycles", c);
      check("rd_timeout_cycles", c, TO + 2);
      check("rd_timeout_busy", busy, 0);
      check("rd_timeout_en_blockread", EN_blockRead, 0);
      check("rd_timeout_no_done", done_cnt, d0);

      // 5. start during FEED and READ ignored; accepted start clears err_timeout
      start_batch();
      feed(6, '0, 1'b1);
      read_back(6, 1'b1, -1);

      // 6. reset mid-READ, then a clean batch
      start_batch();
      feed(8, '0, 1'b0);
      read_back(8, 1'b0, 4);
      start_batch();
      feed(5, '0, 1'b0);
      read_back(5, 1'b0, -1);

      // index wrap beyond batch depth
      start_batch();
      feed(66, '0, 1'b0);
      read_back(66, 1'b0, -1);
      check("wrap_no_errors", {err_underrun, err_timeout}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
